// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: upstream FIFO pop port plus downstream valid/ready word stream.
// master = the reader (drives fifo_read and m_*); slave = the FIFO/sink side.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty;
    logic [7:0]       fifo_status;
    logic             fifo_err_read;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty,
        input  fifo_status,
        input  fifo_err_read,
        input  fifo_data,
        input  m_ready,
        output fifo_read,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_status,
        output fifo_err_read,
        output fifo_data,
        output m_ready,
        input  fifo_read,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops BURST words per frame and emits header + data (+ sum trailer when FIFO_BURST_READER_CHECKSUM_EN is defined).
// Latency: first data word 2 cycles after header transfer, then 1 word/cycle; backpressure via 2-entry buffer throttling pops.
module fifo_burst_reader #(
    parameter int WIDTH = 32,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                reset,
    fifo_burst_reader_if.master bus,
    output logic                busy,
    output logic                err
);
    localparam logic [7:0]       BURST_B = 8'(BURST);
    localparam logic [WIDTH-1:0] HDR     = (WIDTH'(8'hA5) << (WIDTH - 8)) | WIDTH'(BURST_B);

`ifdef FIFO_BURST_READER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_TRAILER} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;
`endif

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       buf_cnt;
    logic             rd_pend;
    logic [7:0]       req_cnt;
    logic [7:0]       out_cnt;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    logic [WIDTH-1:0] sum;
`endif

    logic             data_vld;
    logic             xfer;
    logic             data_xfer;
    logic             last_data;
    logic             buf_push;
    logic             buf_pop;

    // A word returning from the FIFO bypasses the buffer when the buffer is empty.
    assign data_vld  = (buf_cnt != 2'd0) | rd_pend;
    assign xfer      = bus.m_valid & bus.m_ready;
    assign data_xfer = xfer & (state == S_DATA);
    assign last_data = (out_cnt == BURST_B - 8'd1);
    assign buf_push  = rd_pend & ~((buf_cnt == 2'd0) & data_xfer);
    assign buf_pop   = data_xfer & (buf_cnt != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.fifo_status >= BURST_B) state_nxt = S_HEADER;
            end
            S_HEADER: begin
                if (xfer) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (data_xfer && last_data) begin
`ifdef FIFO_BURST_READER_CHECKSUM_EN
                    state_nxt = S_TRAILER;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            S_TRAILER: begin
                if (xfer) state_nxt = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_read = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_data    = '0;
        bus.m_last    = 1'b0;
        busy          = (state != S_IDLE);
        case (state)
            S_HEADER: begin
                bus.m_valid = 1'b1;
                bus.m_data  = HDR;
            end
            S_DATA: begin
                // Buffered words plus in-flight reads never exceed the two buffer slots.
                bus.fifo_read = (req_cnt < BURST_B) && !bus.fifo_empty &&
                                ((buf_cnt + {1'b0, rd_pend}) < 2'd2);
                bus.m_valid   = data_vld;
                if (buf_cnt != 2'd0) begin
                    bus.m_data = buf_mem[rd_ptr];
                end else if (rd_pend) begin
                    bus.m_data = bus.fifo_data;
                end
`ifndef FIFO_BURST_READER_CHECKSUM_EN
                bus.m_last = data_vld & last_data;
`endif
            end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            S_TRAILER: begin
                bus.m_valid = 1'b1;
                bus.m_data  = sum;
                bus.m_last  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend    <= 1'b0;
            req_cnt    <= 8'd0;
            out_cnt    <= 8'd0;
            buf_cnt    <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            err        <= 1'b0;
        end else begin
            rd_pend <= bus.fifo_read;
            if (rd_pend && bus.fifo_err_read) err <= 1'b1;
            if (state == S_IDLE) begin
                req_cnt <= 8'd0;
                out_cnt <= 8'd0;
            end else begin
                if (bus.fifo_read) req_cnt <= req_cnt + 8'd1;
                if (data_xfer)     out_cnt <= out_cnt + 8'd1;
            end
            if (buf_push) begin
                buf_mem[wr_ptr] <= bus.fifo_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (buf_pop) rd_ptr <= ~rd_ptr;
            buf_cnt <= buf_cnt + {1'b0, buf_push} - {1'b0, buf_pop};
        end
    end

`ifdef FIFO_BURST_READER_CHECKSUM_EN
    // Running sum wraps modulo 2^WIDTH; header is not included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (state == S_IDLE) begin
            sum <= '0;
        end else if (data_xfer) begin
            sum <= sum + bus.m_data;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (BURST=4, WIDTH=32) with a small upstream FIFO model and output capture.
module tb_fifo_burst_reader;
    localparam int WIDTH = 32;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    fifo_burst_reader_if #(.WIDTH(WIDTH)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: data appears the cycle after the pop.
    logic [31:0] fmem [0:15];
    int          fwr = 0;
    int          frd = 0;
    int          err_idx = -1;
    bit          status_ovr = 1'b0;
    logic [7:0]  status_val = 8'd0;

    assign bus.fifo_empty  = (fwr == frd);
    assign bus.fifo_status = status_ovr ? status_val : 8'(fwr - frd);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.fifo_data     <= '0;
            bus.fifo_err_read <= 1'b0;
        end else begin
            bus.fifo_err_read <= bus.fifo_read && (frd == err_idx);
            if (bus.fifo_read && (fwr != frd)) begin
                bus.fifo_data <= fmem[frd[3:0]];
                frd           <= frd + 1;
            end
        end
    end

    logic [31:0] cap_d [$];
    bit          cap_l [$];
    int          cap_c [$];

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            cap_d.push_back(bus.m_data);
            cap_l.push_back(bus.m_last);
            cap_c.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        fmem[fwr[3:0]] = d;
        fwr = fwr + 1;
    endtask

    task automatic clear_caps();
        cap_d.delete();
        cap_l.delete();
        cap_c.delete();
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cap_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.fifo_read !== 1'b0) begin bad++; $display("FAIL reset_fifo_read got=%b exp=0", bus.fifo_read); end
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
        total++; if (bus.m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b exp=0", bus.m_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] ed [5] = '{32'hA5000004, 32'd10, 32'd20, 32'd30, 32'd40};
        bit          el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit          ok;
        bus.m_ready = 1'b1;
        clear_caps();
        push(32'd10); push(32'd20); push(32'd30); push(32'd40);
        wait_caps(5, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d words exp=5", cap_d.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
                    bad++; $display("FAIL basic_word%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], ed[i], el[i]);
                end
            end
            total++; if (cap_c[1] - cap_c[0] != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", cap_c[1] - cap_c[0]); end
            total++; if (cap_c[4] - cap_c[1] != 3) begin bad++; $display("FAIL basic_throughput got=%0d exp=3", cap_c[4] - cap_c[1]); end
        end
    endtask

    task automatic test_threshold();
        logic [31:0] ed [5] = '{32'hA5000004, 32'h11, 32'h22, 32'h33, 32'h44};
        int          idle_bad = 0;
        bit          ok;
        bus.m_ready = 1'b1;
        clear_caps();
        push(32'h11); push(32'h22); push(32'h33);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || bus.fifo_read !== 1'b0) idle_bad++;
        end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL thr_idle got=%0d active cycles exp=0", idle_bad); end
        push(32'h44);
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL thr_start got=%b exp=1", busy); end
        status_ovr = 1'b1;
        status_val = 8'd0;
        wait_caps(5, 40, ok);
        status_ovr = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL thr_timeout got=%0d words exp=5", cap_d.size()); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_d[i] !== ed[i]) begin bad++; $display("FAIL thr_word%0d got=%h exp=%h", i, cap_d[i], ed[i]); end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ed [5] = '{32'hA5000004, 32'd0, 32'd1, 32'd2, 32'd3};
        bit          el [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit          held_v = 1'b0;
        logic [31:0] held_d = '0;
        clear_caps();
        bus.m_ready = pat[0];
        push(32'd0); push(32'd1); push(32'd2); push(32'd3);
        for (int i = 0; i < 80; i++) begin
            bus.m_ready = pat[i % 4];
            @(negedge clk);
            if (held_v) begin
                total++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== held_d) begin
                    bad++; $display("FAIL stall_stable cycle=%0d got=%b/%h exp=1/%h", i, bus.m_valid, bus.m_data, held_d);
                end
            end
            held_v = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            held_d = bus.m_data;
            @(posedge clk);
            #1;
            if (cap_d.size() >= 5 && busy === 1'b0) break;
        end
        bus.m_ready = 1'b1;
        total++; if (cap_d.size() != 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", cap_d.size()); end
        if (cap_d.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
                    bad++; $display("FAIL stall_word%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], ed[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_checksum();
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        localparam int NW = 6;
        logic [31:0] ed [6] = '{32'hA5000004, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd3, 32'h00000005};
        bit          el [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        localparam int NW = 5;
        logic [31:0] ed [6] = '{32'hA5000004, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd3, 32'd0};
        bit          el [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
        bit ok;
        bus.m_ready = 1'b1;
        clear_caps();
        push(32'hFFFFFFFF); push(32'd1); push(32'd2); push(32'd3);
        wait_caps(NW, 40, ok);
        tick();
        total++; if (!ok || cap_d.size() != NW) begin bad++; $display("FAIL csum_count got=%0d exp=%0d", cap_d.size(), NW); end
        if (ok) begin
            for (int i = 0; i < NW; i++) begin
                total++;
                if (cap_d[i] !== ed[i] || cap_l[i] !== el[i]) begin
                    bad++; $display("FAIL csum_word%0d got=%h/%b exp=%h/%b", i, cap_d[i], cap_l[i], ed[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ed [5] = '{32'hA5000004, 32'd60, 32'd61, 32'd62, 32'd63};
        bit          ok;
        bus.m_ready = 1'b1;
        clear_caps();
        push(32'd50); push(32'd51); push(32'd52); push(32'd53);
        wait_caps(3, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=%0d words exp=3", cap_d.size()); end
        reset = 1'b0;
        #1;
        total++;
        if ({bus.fifo_read, bus.m_valid, bus.m_last, busy, err} !== 5'b0) begin
            bad++; $display("FAIL rmid_ctrl got=%b exp=00000", {bus.fifo_read, bus.m_valid, bus.m_last, busy, err});
        end
        total++; if (bus.m_data !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", bus.m_data); end
        fwr = frd;
        tick();
        clear_caps();
        reset = 1'b1;
        push(32'd60); push(32'd61); push(32'd62); push(32'd63);
        wait_caps(5, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_fresh_timeout got=%0d words exp=5", cap_d.size()); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_d[i] !== ed[i]) begin bad++; $display("FAIL rmid_word%0d got=%h exp=%h", i, cap_d[i], ed[i]); end
            end
        end
    endtask

    task automatic test_err();
        logic [31:0] ed [5] = '{32'hA5000004, 32'd7, 32'd8, 32'd9, 32'd10};
        bit          ok;
        bus.m_ready = 1'b1;
        clear_caps();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_initial got=%b exp=0", err); end
        err_idx = frd + 1;
        push(32'd7); push(32'd8); push(32'd9); push(32'd10);
        wait_caps(5, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL err_timeout got=%0d words exp=5", cap_d.size()); end
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_d[i] !== ed[i]) begin bad++; $display("FAIL err_word%0d got=%h exp=%h", i, cap_d[i], ed[i]); end
            end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
        err_idx = -1;
        repeat (5) tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        reset = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_threshold();
        test_stall();
        test_checksum();
        test_reset_mid();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
